// File: rtl/id_ex_skid.sv
// Pipeline stage with a valid/ready handshake, an optional two-entry skid buffer and synchronous flush.
// Empty slots always hold NOP_PAYLOAD, so out_payload needs no masking when out_valid is low.
module id_ex_skid #(
    parameter int                   PAYLOAD_W   = 81,
    parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0,
    parameter bit                   SKID        = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [1:0]           count
);

    // The encoding is {main valid, skid valid}; 2'b01 is never entered.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        TWO   = 2'b11
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [PAYLOAD_W-1:0]   main_q;
    logic [PAYLOAD_W-1:0]   skid_q;
    logic                   main_valid;
    logic                   skid_valid;
    logic                   in_fire;
    logic                   out_fire;

    assign main_valid = state[1];
    assign skid_valid = state[0];
    assign in_fire    = in_valid & in_ready & ~flush;
    assign out_fire   = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_next = ONE;
                end
            end
            ONE: begin
                if (in_fire && !out_fire && SKID) begin
                    state_next = TWO;
                end else if (!in_fire && out_fire) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_next = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // With the skid buffer, in_ready is a pure state decode, so out_ready has no path to it.
    always_comb begin
        out_valid   = main_valid;
        out_payload = main_q;
        count       = {1'b0, main_valid} + {1'b0, skid_valid};
        if (SKID) begin
            in_ready = ~rst & ~skid_valid;
        end else begin
            in_ready = ~rst & (~main_valid | out_ready);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_q <= NOP_PAYLOAD;
            skid_q <= NOP_PAYLOAD;
        end else begin
            if (state_next == EMPTY) begin
                main_q <= NOP_PAYLOAD;
            end else if (state == TWO && out_fire) begin
                main_q <= skid_q;
            end else if (in_fire && (state == EMPTY || out_fire)) begin
                main_q <= in_payload;
            end

            if (state == TWO && out_fire) begin
                skid_q <= NOP_PAYLOAD;
            end else if (SKID && state == ONE && in_fire && !out_fire) begin
                skid_q <= in_payload;
            end
        end
    end

endmodule
